// File: rtl/alu_muldiv_seq_if.sv
// alu_muldiv_seq_if: bundles the multiply/divide request, result and ALU-borrow
// signals of alu_muldiv_seq.
//   master : the execute stage / ALU side (drives start, op, a, b, alu_portout)
//   slave  : the sequencer (drives busy, done, hi, lo, div_zero, alu_op/porta/portb)
interface alu_muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_porta;
  logic [WIDTH-1:0] alu_portb;
  logic [WIDTH-1:0] alu_portout;

  modport master (
    output start, op, a, b, alu_portout,
    input  busy, done, hi, lo, div_zero, alu_op, alu_porta, alu_portb
  );

  modport slave (
    input  start, op, a, b, alu_portout,
    output busy, done, hi, lo, div_zero, alu_op, alu_porta, alu_portb
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: multi-cycle MULTU/DIVU sequencer that borrows the shared
// execute-stage ALU. Each result bit takes two ALU cycles using only ADD, SUB
// and SLTU; carries and borrows are recovered through SLTU.
// Ports:
//   CLK  - clock, rising edge
//   RST  - synchronous active-high reset
//   bus  - alu_muldiv_seq_if.slave: start/op/a/b request, busy/done/div_zero
//          status, hi/lo results, alu_op/alu_porta/alu_portb to the ALU and
//          alu_portout back from it (combinational, same cycle).
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic               CLK,
  input  logic               RST,
  alu_muldiv_seq_if.slave    bus
);

  localparam int CW = $clog2(WIDTH);

  // aluop_t encodings used by the execute-stage ALU
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLTU = 4'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             phase_q, phase_d;
  logic             op_q, op_d;
  logic             f_q, f_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] t_q, t_d;

  logic             accept_s;
  logic             div0_s;
  logic             last_s;
  logic [WIDTH-1:0] addend_s;
  logic [WIDTH-1:0] rem_s;

  // Accept only while not running; a zero divisor short-circuits to DONE
  assign accept_s = bus.start && (state_q != S_RUN);
  assign div0_s   = bus.op && (bus.b == {WIDTH{1'b0}});
  assign last_s   = phase_q && (count_q == CW'(WIDTH - 1));
  assign addend_s = lo_q[0] ? d_q : {WIDTH{1'b0}};
  // Partial remainder shifted left by one, taking in the next dividend bit
  assign rem_s    = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          state_d = div0_s ? S_DONE : S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (last_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: status decode and ALU operand/op steering
  always_comb begin
    bus.busy      = (state_q == S_RUN);
    bus.done      = (state_q == S_DONE);
    bus.alu_op    = ALU_ADD;
    bus.alu_porta = {WIDTH{1'b0}};
    bus.alu_portb = {WIDTH{1'b0}};
    if (state_q == S_RUN) begin
      if (!op_q) begin
        // MULTU: phase 0 adds the partial product, phase 1 recovers the carry
        bus.alu_op    = phase_q ? ALU_SLTU : ALU_ADD;
        bus.alu_porta = phase_q ? t_q : hi_q;
        bus.alu_portb = addend_s;
      end else begin
        // DIVU: phase 0 compares, phase 1 subtracts
        bus.alu_op    = phase_q ? ALU_SUB : ALU_SLTU;
        bus.alu_porta = phase_q ? t_q : rem_s;
        bus.alu_portb = d_q;
      end
    end else begin
      bus.alu_op    = ALU_ADD;
      bus.alu_porta = {WIDTH{1'b0}};
      bus.alu_portb = {WIDTH{1'b0}};
    end
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_zero = dz_q;

  // Datapath next-state: operand load on accept, one half-iteration per RUN cycle
  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    op_d    = op_q;
    f_d     = f_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    d_d     = d_q;
    t_d     = t_q;
    if (accept_s) begin
      hi_d    = {WIDTH{1'b0}};
      lo_d    = bus.a;
      d_d     = bus.b;
      count_d = {CW{1'b0}};
      phase_d = 1'b0;
      op_d    = bus.op;
      dz_d    = 1'b0;
      if (div0_s) begin
        hi_d = bus.a;
        lo_d = {WIDTH{1'b1}};
        dz_d = 1'b1;
      end else begin
        dz_d = 1'b0;
      end
    end else if (state_q == S_RUN) begin
      phase_d = ~phase_q;
      if (phase_q) begin
        count_d = count_q + CW'(1);
      end else begin
        count_d = count_q;
      end
      case ({op_q, phase_q})
        2'b00: t_d = bus.alu_portout;
        // Carry out of hi+addend is (sum < addend)
        2'b01: begin
          hi_d = {bus.alu_portout[0], t_q[WIDTH-1:1]};
          lo_d = {t_q[0], lo_q[WIDTH-1:1]};
        end
        // Subtract when r >= d, or when a 1 was shifted out of hi
        2'b10: begin
          t_d = rem_s;
          f_d = hi_q[WIDTH-1] | ~bus.alu_portout[0];
        end
        2'b11: begin
          hi_d = f_q ? bus.alu_portout : t_q;
          lo_d = {lo_q[WIDTH-2:0], f_q};
        end
        default: t_d = t_q;
      endcase
    end else begin
      phase_d = phase_q;
    end
  end

  // Datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= {CW{1'b0}};
      phase_q <= 1'b0;
      op_q    <= 1'b0;
      f_q     <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      d_q     <= {WIDTH{1'b0}};
      t_q     <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
      op_q    <= op_d;
      f_q     <= f_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      d_q     <= d_d;
      t_q     <= t_d;
    end
  end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Multi-cycle sequencer for the shared 32-bit ALU that performs MULTU and DIVU.
- Drives only the ALU's existing ADD, SUB and SLTU operations, two ALU cycles per result bit, so no dedicated multiplier or divider is needed.
- Sits in the execute stage beside the ALU. While busy it owns the ALU operand and op inputs; the stage mux hands the ALU to it.
- Results land in hi/lo and are held until the next accepted start.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  synchronous active-high reset
start  input  1  request pulse/level; accepted when busy is low
op  input  1  0 = MULTU, 1 = DIVU
a  input  WIDTH  multiplicand / dividend, sampled on accept
b  input  WIDTH  multiplier / divisor, sampled on accept
busy  output  1  high while an operation is in RUN
done  output  1  one-cycle pulse, results valid
hi  output  WIDTH  MULTU upper product / DIVU remainder
lo  output  WIDTH  MULTU lower product / DIVU quotient
div_zero  output  1  set with done when DIVU had b == 0; cleared on next accept
alu_op  output  4  aluop_t from cpu_types_pkg, drives the ALU op input
alu_porta  output  WIDTH  ALU operand A
alu_portb  output  WIDTH  ALU operand B
alu_portout  input  WIDTH  ALU result; combinational, same cycle

Behaviour:
- Reset: state = IDLE; busy, done and div_zero = 0; hi and lo = 0; alu_op = ALU_ADD; alu_porta and alu_portb = 0.
- RST high mid-operation aborts the operation, returns to reset values on the next edge, and produces no done.
- States: IDLE, RUN, DONE. Internal registers:
  - 5-bit iteration count
  - phase bit
  - divisor/multiplicand register d
  - temp register t
  - flag f
- Accept rule: start is accepted in IDLE or DONE (busy low). start is ignored while busy.
- On accept:
  - hi <= 0, lo <= a, d <= b, count <= 0, phase <= 0, div_zero <= 0.
  - Go to RUN. Exception: DIVU with b == 0 goes straight to DONE with hi <= a, lo <= all ones, div_zero <= 1.
- In RUN, busy = 1. In IDLE and DONE the ALU outputs sit at idle values (ALU_ADD, operands 0).
- MULTU, phase 0:
  - alu_op = ALU_ADD, porta = hi, portb = lo[0] ? d : 0.
  - t <= alu_portout.
- MULTU, phase 1:
  - alu_op = ALU_SLTU, porta = t, portb = same addend as phase 0.
  - Carry c = alu_portout[0].
  - hi <= {c, t[WIDTH-1:1]}, lo <= {t[0], lo[WIDTH-1:1]}.
- DIVU, phase 0:
  - Form r = {hi[WIDTH-2:0], lo[WIDTH-1]}.
  - alu_op = ALU_SLTU, porta = r, portb = d.
  - t <= r, f <= hi[WIDTH-1] | ~alu_portout[0].
- DIVU, phase 1:
  - alu_op = ALU_SUB, porta = t, portb = d.
  - hi <= f ? alu_portout : t, lo <= {lo[WIDTH-2:0], f}.
- Phase toggles every RUN cycle. count increments after each phase 1.
- After phase 1 with count == WIDTH-1, go to DONE.
- Latency:
  - start high in cycle 0 gives RUN in cycles 1..2*WIDTH and done high in cycle 2*WIDTH+1 (65 for WIDTH = 32).
  - Divide-by-zero gives done in cycle 1.
- DONE lasts exactly one cycle, then IDLE, unless start is high in DONE; then the new op is accepted and the next state is RUN (or DONE for divide-by-zero).
- hi, lo and div_zero are stable from done until the next accept.
- All arithmetic is unsigned, modulo 2^WIDTH. Carry and borrow are recovered only through SLTU as above; no wider adders are allowed.

Test Plan:
- MULTU a=7, b=6, start one cycle -> busy cycles 1..64, done cycle 65, hi=0, lo=42, div_zero=0; alu_op toggles ADD/SLTU each RUN cycle.
- MULTU a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001 (exercises carry path every iteration).
- DIVU a=100, b=7 -> lo=14, hi=2; DIVU a=FFFFFFFF, b=80000001 -> lo=1, hi=7FFFFFFE (exercises shifted-out MSB forcing subtract).
- DIVU a=1234, b=0 -> done cycle 1, div_zero=1, hi=1234, lo=FFFFFFFF, busy never high.
- start re-pulsed at cycle 10 with different operands during MULTU 7*6 -> ignored, result still 42. start held high through DONE -> back-to-back op accepted, second done at cycle 130.
- RST asserted at cycle 30 of a DIVU -> next cycle busy=0, hi=lo=0, alu_op=ALU_ADD with zero operands, no done pulse; a following MULTU 3*5 gives lo=15.
